// File: rtl/voice_allocator.sv
// voice_allocator: schedules song-reader notes onto a bank of note players,
// reusing the least recently loaded voice when all are busy and STEAL_EN is set.
module voice_allocator #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_WIDTH = 6,
    parameter int DUR_WIDTH  = 6,
    parameter int STEAL_EN   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  beat,
    input  logic                  note_valid,
    input  logic [NOTE_WIDTH-1:0] note_in,
    input  logic [DUR_WIDTH-1:0]  dur_in,
    output logic                  note_ready,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_WIDTH-1:0] voice_note,
    output logic [DUR_WIDTH-1:0]  voice_dur,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic                  steal
);
    localparam int RW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, ALLOC, LOAD} state_t;

    state_t                               state, state_d;
    logic [NOTE_WIDTH-1:0]                note_q;
    logic [DUR_WIDTH-1:0]                 dur_q;
    logic [RW-1:0]                        tgt_q, pick, oldest;
    logic                                 tgt_busy_q, any_free, tick, in_load;
    logic [NUM_VOICES-1:0][DUR_WIDTH-1:0] cnt;
    logic [NUM_VOICES-1:0][RW-1:0]        rank;
    logic [NUM_VOICES-1:0]                nz;

    assign tick    = beat & play_enable;
    assign in_load = (state == LOAD);

    // Lowest-index free voice wins; otherwise the voice holding the top age rank.
    always_comb begin
        any_free = 1'b0;
        pick     = '0;
        oldest   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (rank[i] == RW'(NUM_VOICES - 1)) oldest = RW'(i);
            if (!nz[i]) begin
                any_free = 1'b1;
                pick     = RW'(i);
            end
        end
        if (!any_free) pick = oldest;
    end

    always_comb begin
        state_d    = state;
        note_ready = 1'b0;
        case (state)
            IDLE: begin
                note_ready = reset & play_enable & (any_free | (STEAL_EN != 0));
                if (note_valid && note_ready) state_d = ALLOC;
            end
            ALLOC:   state_d = (dur_q == '0) ? IDLE : LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            note_q     <= '0;
            dur_q      <= '0;
            tgt_q      <= '0;
            tgt_busy_q <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && note_valid && note_ready) begin
                note_q <= note_in;
                dur_q  <= dur_in;
            end
            if (state == ALLOC) begin
                tgt_q      <= pick;
                tgt_busy_q <= nz[pick];
            end
        end
    end

    assign voice_load = in_load ? (NUM_VOICES'(1) << tgt_q) : '0;
    assign voice_note = in_load ? note_q : '0;
    assign voice_dur  = in_load ? dur_q : '0;
    assign steal      = in_load & tgt_busy_q;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        logic [DUR_WIDTH-1:0] c;
        logic [RW-1:0]        r;
        logic                 b, bump;

        // Voices younger than the target age by one; the target becomes youngest.
        assign bump = in_load && (r < rank[tgt_q]);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                c <= '0;
                b <= 1'b0;
                r <= RW'(i);
            end else begin
                if (voice_load[i])         c <= dur_q;
                else if (tick && c != '0)  c <= c - DUR_WIDTH'(1);
                b <= (c != '0);
                if (voice_load[i])         r <= '0;
                else if (bump)             r <= r + RW'(1);
            end
        end

        assign cnt[i]        = c;
        assign rank[i]       = r;
        assign nz[i]         = (c != '0);
        assign voice_busy[i] = b;
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: a stealing and a stalling instance share
// stimulus; sel picks which one receives notes and is observed.
module tb_voice_allocator;
    logic       clk = 1'b0, reset = 1'b0, pe = 1'b0, beat = 1'b0, valid = 1'b0, sel = 1'b0;
    logic [5:0] note_in = '0, dur_in = '0;
    logic       rdy_a, rdy_b, steal_a, steal_b;
    logic [2:0] load_a, load_b, busy_a, busy_b;
    logic [5:0] vn_a, vn_b, vd_a, vd_b;
    logic       rdy_s, steal_s;
    logic [2:0] load_s, busy_s;
    logic [5:0] vn_s, vd_s;
    int         n_cmp = 0, n_err = 0;
    int         w;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(3), .NOTE_WIDTH(6), .DUR_WIDTH(6), .STEAL_EN(1)) u_a (
        .clk(clk), .reset(reset), .play_enable(pe), .beat(beat), .note_valid(valid & ~sel),
        .note_in(note_in), .dur_in(dur_in), .note_ready(rdy_a), .voice_load(load_a),
        .voice_note(vn_a), .voice_dur(vd_a), .voice_busy(busy_a), .steal(steal_a));

    voice_allocator #(.NUM_VOICES(3), .NOTE_WIDTH(6), .DUR_WIDTH(6), .STEAL_EN(0)) u_b (
        .clk(clk), .reset(reset), .play_enable(pe), .beat(beat), .note_valid(valid & sel),
        .note_in(note_in), .dur_in(dur_in), .note_ready(rdy_b), .voice_load(load_b),
        .voice_note(vn_b), .voice_dur(vd_b), .voice_busy(busy_b), .steal(steal_b));

    assign rdy_s   = sel ? rdy_b   : rdy_a;
    assign steal_s = sel ? steal_b : steal_a;
    assign load_s  = sel ? load_b  : load_a;
    assign busy_s  = sel ? busy_b  : busy_a;
    assign vn_s    = sel ? vn_b    : vn_a;
    assign vd_s    = sel ? vd_b    : vd_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        step();
        beat = 1'b0;
    endtask

    // Offer a note and wait for the handshake; returns in the ALLOC cycle.
    task automatic send(input logic [5:0] n, input logic [5:0] d, output int waited);
        waited  = 0;
        note_in = n;
        dur_in  = d;
        valid   = 1'b1;
        @(negedge clk);
        while (!rdy_s && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_rdy", rdy_s, 1);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Expect no strobe in ALLOC, then the given strobe in LOAD (optional beat there).
    task automatic expl(input logic lb, input logic [2:0] el, input logic [5:0] en,
                        input logic [5:0] ed, input logic es);
        @(negedge clk);
        chk("alloc_load", load_s, 0);
        @(posedge clk); #1;
        beat = lb;
        @(negedge clk);
        chk("voice_load", load_s, el);
        chk("voice_note", vn_s, en);
        chk("voice_dur", vd_s, ed);
        chk("steal", steal_s, es);
        @(posedge clk); #1;
        beat = 1'b0;
    endtask

    initial begin
        // reset held with a pending note and playback stopped
        valid = 1'b1;
        @(negedge clk);
        chk("rst_rdy_a", rdy_a, 0);
        chk("rst_rdy_b", rdy_b, 0);
        chk("rst_load", load_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_steal", steal_a, 0);
        chk("rst_note", vn_a, 0);
        step();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("pe0_rdy", rdy_a, 0);
            chk("pe0_load", load_a, 0);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        pe    = 1'b1;

        // three notes fill voices 0,1,2 in order
        send(6'd10, 6'd4, w); expl(1'b0, 3'b001, 6'd10, 6'd4, 1'b0);
        send(6'd20, 6'd4, w); expl(1'b0, 3'b010, 6'd20, 6'd4, 1'b0);
        send(6'd30, 6'd4, w); expl(1'b0, 3'b100, 6'd30, 6'd4, 1'b0);
        step();
        @(negedge clk);
        chk("busy_full", busy_a, 3'b111);

        // all busy: oldest (voice 0) stolen, then voice 1
        @(posedge clk); #1;
        send(6'd40, 6'd2, w); expl(1'b0, 3'b001, 6'd40, 6'd2, 1'b1);
        send(6'd50, 6'd1, w); expl(1'b0, 3'b010, 6'd50, 6'd1, 1'b1);

        // non-stealing instance stalls until four beats drain its voices
        sel = 1'b1;
        send(6'd10, 6'd4, w); expl(1'b0, 3'b001, 6'd10, 6'd4, 1'b0);
        send(6'd20, 6'd4, w); expl(1'b0, 3'b010, 6'd20, 6'd4, 1'b0);
        send(6'd30, 6'd4, w); expl(1'b0, 3'b100, 6'd30, 6'd4, 1'b0);
        step();
        @(negedge clk);
        chk("b_busy_full", busy_s, 3'b111);
        note_in = 6'd40;
        dur_in  = 6'd2;
        valid   = 1'b1;
        @(negedge clk);
        chk("stall_rdy0", rdy_s, 0);
        for (int k = 0; k < 3; k++) begin
            pulse_beat();
            @(negedge clk);
            chk("stall_rdy", rdy_s, 0);
        end
        pulse_beat();
        send(6'd40, 6'd2, w);
        chk("stall_wait", w, 0);
        expl(1'b0, 3'b001, 6'd40, 6'd2, 1'b0);
        sel = 1'b0;

        // countdown; beat with playback stopped is ignored
        do_reset();
        send(6'd5, 6'd2, w); expl(1'b0, 3'b001, 6'd5, 6'd2, 1'b0);
        pe = 1'b0;
        pulse_beat();
        pe = 1'b1;
        step();
        @(negedge clk);
        chk("pe0_beat_busy", busy_a, 3'b001);
        @(posedge clk); #1;
        pulse_beat();
        step();
        @(negedge clk);
        chk("beat1_busy", busy_a, 3'b001);
        @(posedge clk); #1;
        pulse_beat();
        @(negedge clk);
        chk("busy_lag", busy_a, 3'b001);
        @(posedge clk); #1;
        @(negedge clk);
        chk("beat2_busy", busy_a, 3'b000);

        // beat during LOAD: target takes dur, the others decrement
        do_reset();
        send(6'd1, 6'd5, w); expl(1'b0, 3'b001, 6'd1, 6'd5, 1'b0);
        send(6'd2, 6'd1, w); expl(1'b0, 3'b010, 6'd2, 6'd1, 1'b0);
        send(6'd3, 6'd5, w); expl(1'b0, 3'b100, 6'd3, 6'd5, 1'b0);
        pulse_beat();
        step();
        @(negedge clk);
        chk("v1_free", busy_a, 3'b101);
        @(posedge clk); #1;
        send(6'd9, 6'd3, w); expl(1'b1, 3'b010, 6'd9, 6'd3, 1'b0);
        pulse_beat();
        pulse_beat();
        step();
        @(negedge clk);
        chk("ldbeat_busy", busy_a, 3'b111);
        @(posedge clk); #1;
        pulse_beat();
        step();
        @(negedge clk);
        chk("ldbeat_done", busy_a, 3'b000);

        // rest note: accepted, dropped, back in IDLE two cycles after accept
        @(posedge clk); #1;
        send(6'd7, 6'd0, w);
        @(negedge clk);
        chk("rest_alloc_load", load_a, 0);
        chk("rest_alloc_rdy", rdy_a, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rest_load", load_a, 0);
        chk("rest_steal", steal_a, 0);
        chk("rest_idle_rdy", rdy_a, 1);

        // reset during LOAD discards the note
        @(posedge clk); #1;
        send(6'd11, 6'd3, w);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstld_load", load_a, 0);
        chk("rstld_note", vn_a, 0);
        chk("rstld_dur", vd_a, 0);
        chk("rstld_steal", steal_a, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_load", load_a, 0);
            chk("post_rst_busy", busy_a, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
